// File: rtl/pkg_rr_pkg.sv
// Shared definitions for the packet round-robin port arbiter: port count,
// byte width, index widths and one-hot helpers.
package pkg_rr_pkg;

  localparam int NUM_PORT = 8;
  localparam int DATA_W   = 8;
  localparam int CH_W     = 3;  // holds a channel index for up to 8 channels
  localparam int PORT_W   = 3;  // holds a port index for NUM_PORT ports

  // Index of the set bit of a one-hot port request (0 for an empty vector).
  function automatic logic [PORT_W-1:0] onehot_to_idx(input logic [NUM_PORT-1:0] oh);
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (oh[i]) idx = idx | PORT_W'(i);
    end
    return idx;
  endfunction

  // True only when exactly one bit of the request is set.
  function automatic logic is_onehot(input logic [NUM_PORT-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Rotating-priority picker for one output port: returns the first requester
// at or above ptr, wrapping to the lowest requester below it.
// Optional feature macro: PKG_RR_QOS_PRIO_EN (qos=1 requesters form the
// higher class; rotation then applies within that class only).
module rr_arb_core import pkg_rr_pkg::*; #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] qos,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   winner,
  output logic              found
);

  logic [NUM_CH-1:0] pool;
  logic [NUM_CH-1:0] upper;
  logic [NUM_CH-1:0] pick;

`ifdef PKG_RR_QOS_PRIO_EN
  // Narrow the candidates to the qos class when any qos requester exists.
  always_comb pool = (|(req & qos)) ? (req & qos) : req;
`else
  // qos does not influence the choice; it is only forwarded by the top.
  logic unused_qos;
  assign unused_qos = ^qos;
  always_comb pool = req;
`endif

  // Prefer requesters at or above ptr; fall back to the full pool (wrap),
  // then take the lowest set bit of the chosen set.
  always_comb begin
    upper  = pool & ~((NUM_CH'(1) << ptr) - NUM_CH'(1));
    pick   = (|upper) ? upper : pool;
    found  = |pick;
    winner = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pick[c]) winner = CH_W'(c);
    end
  end

endmodule

// File: rtl/pkg_rr_arb.sv
// Packet round-robin arbiter: NUM_CH read channels each post a one-hot port
// request; every port keeps a registered owner, busy bit and rotation pointer,
// and muxes its owner's byte/flags through combinationally while busy.
// Optional feature macro: PKG_RR_QOS_PRIO_EN (see rr_arb_core).
module pkg_rr_arb import pkg_rr_pkg::*; #(
  parameter int NUM_CH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*NUM_PORT-1:0] ch_req,
  output logic [NUM_CH*NUM_PORT-1:0] ch_ack,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]          ch_sop,
  input  logic [NUM_CH-1:0]          ch_eop,
  input  logic [NUM_CH-1:0]          ch_qos,
  output logic [NUM_PORT*DATA_W-1:0] port_data,
  output logic [NUM_PORT-1:0]        port_vld,
  output logic [NUM_PORT-1:0]        port_sop,
  output logic [NUM_PORT-1:0]        port_eop,
  output logic [NUM_PORT-1:0]        port_qos
);

  logic [NUM_CH-1:0]   req_ok;
  logic [PORT_W-1:0]   req_port [NUM_CH];
  logic [NUM_CH-1:0]   owns_any;
  logic [NUM_PORT-1:0] busy;
  logic [CH_W-1:0]     owner [NUM_PORT];

  // Decode each channel's request once: validity and target port.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign req_ok[gi]   = is_onehot(ch_req[gi*NUM_PORT +: NUM_PORT]);
    assign req_port[gi] = onehot_to_idx(ch_req[gi*NUM_PORT +: NUM_PORT]);
  end

  // A channel already holding a port may not win another one, including the
  // port it is finishing on, so a lone requester at eop releases the port.
  always_comb begin
    owns_any = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int p = 0; p < NUM_PORT; p++) begin
        if (busy[p] && owner[p] == CH_W'(c)) owns_any[c] = 1'b1;
      end
    end
  end

  // Ack follows the request only when the channel owns the port it targets.
  always_comb begin
    ch_ack = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int p = 0; p < NUM_PORT; p++) begin
        if (busy[p] && owner[p] == CH_W'(c) && req_ok[c] && ch_req[c*NUM_PORT + p])
          ch_ack[c*NUM_PORT + p] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_port
    logic              busy_reg;
    logic [CH_W-1:0]   owner_reg;
    logic [CH_W-1:0]   rr_ptr_reg;
    logic [NUM_CH-1:0] cand;
    logic [CH_W-1:0]   win;
    logic              found;
    logic              owner_eop;
    logic              arb_en;
    logic [DATA_W-1:0] o_data;
    logic              o_sop, o_eop, o_qos;

    // Eligible requesters for this port: valid, targeting it, holding nothing.
    always_comb begin
      cand = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cand[c] = req_ok[c] && (req_port[c] == PORT_W'(gi)) && !owns_any[c];
      end
    end

    rr_arb_core #(.NUM_CH(NUM_CH)) u_core (
      .req    (cand),
      .qos    (ch_qos),
      .ptr    (rr_ptr_reg),
      .winner (win),
      .found  (found)
    );

    // Owner mux: forward the owner's byte and flags while busy, zeros otherwise.
    always_comb begin
      o_data    = '0;
      o_sop     = 1'b0;
      o_eop     = 1'b0;
      o_qos     = 1'b0;
      owner_eop = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (owner_reg == CH_W'(c)) begin
          owner_eop = ch_eop[c];
          if (busy_reg) begin
            o_data = ch_data[c*DATA_W +: DATA_W];
            o_sop  = ch_sop[c];
            o_eop  = ch_eop[c];
            o_qos  = ch_qos[c];
          end
        end
      end
    end

    assign arb_en = !busy_reg || owner_eop;

    // Re-arbitrate when free or on the owner's last beat; the winner takes
    // over next cycle with no bubble, otherwise the port goes idle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        busy_reg   <= 1'b0;
        owner_reg  <= '0;
        rr_ptr_reg <= '0;
      end else if (arb_en) begin
        busy_reg <= found;
        if (found) begin
          owner_reg  <= win;
          rr_ptr_reg <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
      end
    end

    assign busy[gi]                          = busy_reg;
    assign owner[gi]                         = owner_reg;
    assign port_vld[gi]                      = busy_reg;
    assign port_sop[gi]                      = o_sop;
    assign port_eop[gi]                      = o_eop;
    assign port_qos[gi]                      = o_qos;
    assign port_data[gi*DATA_W +: DATA_W]    = o_data;
  end

endmodule

// File: tb/tb_pkg_rr_arb.sv
// Bench for pkg_rr_arb: directed scenarios followed by randomized traffic,
// every cycle compared against a per-port ownership model.
module tb_pkg_rr_arb;
  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH*8-1:0] ch_req  = '0;
  logic [NUM_CH*8-1:0] ch_data = '0;
  logic [NUM_CH*8-1:0] ch_ack;
  logic [NUM_CH-1:0] ch_sop = '0, ch_eop = '0, ch_qos = '0;
  logic [63:0]       port_data;
  logic [7:0]        port_vld, port_sop, port_eop, port_qos;

  int passed = 0;
  int total  = 0;
  int m_owner [8];   // -1 when the port is free
  int m_ptr   [8];

  always #5 clk = ~clk;

  pkg_rr_arb #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_ack(ch_ack), .ch_data(ch_data),
    .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_qos(ch_qos), .port_data(port_data),
    .port_vld(port_vld), .port_sop(port_sop), .port_eop(port_eop), .port_qos(port_qos)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int p = 0; p < 8; p++) begin
      m_owner[p] = -1;
      m_ptr[p]   = 0;
    end
  endfunction

  // Target port of a channel, or -1 if the request is not exactly one-hot.
  function automatic int req_port(input int c);
    logic [7:0] r;
    r = ch_req[c*8 +: 8];
    if ($countones(r) != 1) return -1;
    for (int p = 0; p < 8; p++) if (r[p]) return p;
    return -1;
  endfunction

  function automatic bit holds_port(input int c);
    for (int p = 0; p < 8; p++) if (m_owner[p] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Next ownership: free ports, or ports whose owner is at eop, go to the
  // eligible channel closest at/after the pointer in circular distance.
  function automatic void model_step();
    int nxt [8];
    int pool [$];
    int hi [$];
    int best, bestd, d;
    if (rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 8; p++) begin
      nxt[p] = m_owner[p];
      if (m_owner[p] < 0 || ch_eop[m_owner[p]]) begin
        pool.delete();
        hi.delete();
        for (int c = 0; c < NUM_CH; c++)
          if (req_port(c) == p && !holds_port(c)) pool.push_back(c);
`ifdef PKG_RR_QOS_PRIO_EN
        foreach (pool[i]) if (ch_qos[pool[i]]) hi.push_back(pool[i]);
        if (hi.size() > 0) pool = hi;
`endif
        best  = -1;
        bestd = NUM_CH;
        foreach (pool[i]) begin
          d = (pool[i] - m_ptr[p] + NUM_CH) % NUM_CH;
          if (d < bestd) begin
            bestd = d;
            best  = pool[i];
          end
        end
        nxt[p] = best;
        if (best >= 0) m_ptr[p] = (best + 1) % NUM_CH;
      end
    end
    for (int p = 0; p < 8; p++) m_owner[p] = nxt[p];
  endfunction

  task automatic model_check(input string tag);
    logic [NUM_CH*8-1:0] e_ack;
    logic [63:0] e_data;
    logic [7:0]  e_vld, e_sop, e_eop, e_qos;
    int o;
    e_ack = '0; e_data = '0; e_vld = '0; e_sop = '0; e_eop = '0; e_qos = '0;
    for (int p = 0; p < 8; p++) begin
      o = m_owner[p];
      if (o >= 0) begin
        e_vld[p]         = 1'b1;
        e_data[p*8 +: 8] = ch_data[o*8 +: 8];
        e_sop[p]         = ch_sop[o];
        e_eop[p]         = ch_eop[o];
        e_qos[p]         = ch_qos[o];
        if (req_port(o) == p) e_ack[o*8 + p] = 1'b1;
      end
    end
    chk({tag, "_ack"},  ch_ack,    e_ack);
    chk({tag, "_vld"},  port_vld,  e_vld);
    chk({tag, "_data"}, port_data, e_data);
    chk({tag, "_sop"},  port_sop,  e_sop);
    chk({tag, "_eop"},  port_eop,  e_eop);
    chk({tag, "_qos"},  port_qos,  e_qos);
  endtask

  // One clock: check settled outputs mid-cycle, advance model, step past edge.
  task automatic tick(input string tag);
    @(negedge clk);
    model_check(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] req, input logic sop,
                        input logic eop, input logic qos, input logic [7:0] data);
    ch_req[c*8 +: 8]  = req;
    ch_sop[c]         = sop;
    ch_eop[c]         = eop;
    ch_qos[c]         = qos;
    ch_data[c*8 +: 8] = data;
  endtask

  // Drop all requests and close any open packet.
  task automatic idle();
    ch_req = '0;
    ch_sop = '0;
    ch_eop = '1;
    tick("idle");
    ch_eop = '0;
    chk("idle_vld", port_vld, 8'h00);
  endtask

  initial begin
    int sel;
    model_reset();

    // Reset state
    rst = 1'b1;
    tick("rst");
    tick("rst");
    chk("rst_vld", port_vld, 8'h00);
    chk("rst_ack", ch_ack, '0);
    rst = 1'b0;

    // Single request to a free port: ack one cycle later, sop/data forwarded
    set_ch(0, 8'h08, 1'b1, 1'b0, 1'b0, 8'hA5);
    #1 chk("lat_pre_ack", ch_ack, '0);
    tick("p3a");
    chk("p3_ack",  ch_ack[7:0], 8'h08);
    chk("p3_sop",  port_sop[3], 1'b1);
    chk("p3_data", port_data[31:24], 8'hA5);
    set_ch(0, 8'h08, 1'b0, 1'b1, 1'b0, 8'h5A);
    tick("p3b");
    chk("p3_rel", port_vld[3], 1'b0);
    set_ch(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

    // Three channels on port 0: ch0, ch1, ch2 back to back
    for (int c = 0; c < 3; c++) set_ch(c, 8'h01, 1'b1, 1'b0, 1'b0, 8'(8'h10 + c));
    tick("rr_a");
    chk("rr_ack0", ch_ack[7:0], 8'h01);
    chk("rr_vld_b", port_vld[0], 1'b1);
    tick("rr_b");
    chk("rr_hold1", ch_ack[15:8], 8'h00);
    set_ch(0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h11);
    tick("rr_c");
    chk("rr_ack1", ch_ack[15:8], 8'h01);
    chk("rr_ack0_off", ch_ack[7:0], 8'h00);
    chk("rr_vld_d", port_vld[0], 1'b1);
    set_ch(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    set_ch(1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h21);
    tick("rr_d");
    chk("rr_ack2", ch_ack[23:16], 8'h01);
    chk("rr_vld_e", port_vld[0], 1'b1);
    set_ch(1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    set_ch(2, 8'h01, 1'b1, 1'b1, 1'b0, 8'h22);
    tick("rr_e");
    chk("rr_end", port_vld[0], 1'b0);
    set_ch(2, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

    // One-byte packet on port 5
    set_ch(1, 8'h20, 1'b1, 1'b1, 1'b0, 8'h37);
    tick("b1a");
    chk("b1_vld",  port_vld[5], 1'b1);
    chk("b1_ack",  ch_ack[15:8], 8'h20);
    chk("b1_data", port_data[47:40], 8'h37);
    tick("b1b");
    chk("b1_rel", port_vld[5], 1'b0);
    set_ch(1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

    // Multi-hot request is ignored
    set_ch(0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h38);
    tick("mh_a");
    tick("mh_b");
    chk("mh_ack", ch_ack, '0);
    chk("mh_vld", port_vld, 8'h00);
    set_ch(0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

    // ch0 (qos=0) and ch3 (qos=1) on port 2 with its pointer at 0
    set_ch(0, 8'h04, 1'b1, 1'b0, 1'b0, 8'h40);
    set_ch(3, 8'h04, 1'b1, 1'b0, 1'b1, 8'h43);
    tick("qos_a");
`ifdef PKG_RR_QOS_PRIO_EN
    chk("qos_win3", ch_ack[31:24], 8'h04);
    chk("qos_los0", ch_ack[7:0], 8'h00);
    chk("qos_flag", port_qos[2], 1'b1);
`else
    chk("qos_win0", ch_ack[7:0], 8'h04);
    chk("qos_los3", ch_ack[31:24], 8'h00);
    chk("qos_flag", port_qos[2], 1'b0);
`endif
    idle();

    // Reset in the middle of a 10-byte packet on port 7
    set_ch(1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h70);
    tick("ab_a");
    chk("ab_ack", ch_ack[15:8], 8'h80);
    set_ch(1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h71);
    for (int i = 0; i < 4; i++) tick("ab_mid");
    chk("ab_busy", port_vld[7], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ab_vld", port_vld[7], 1'b0);
    chk("ab_ack0", ch_ack, '0);
    model_reset();
    tick("ab_rst");
    rst = 1'b0;
    set_ch(1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h72);
    set_ch(2, 8'h80, 1'b1, 1'b0, 1'b0, 8'h73);
    #1 chk("ab_pre_ack", ch_ack, '0);
    tick("ab_new");
    chk("ab_new_ack1", ch_ack[15:8], 8'h80);
    chk("ab_new_ack2", ch_ack[23:16], 8'h00);
    chk("ab_new_vld", port_vld[7], 1'b1);
    idle();

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(3) == 0) begin
          sel = $urandom_range(19);
          if (sel < 10)      ch_req[c*8 +: 8] = 8'(1 << $urandom_range(1));
          else if (sel < 15) ch_req[c*8 +: 8] = 8'(1 << $urandom_range(7));
          else if (sel < 17) ch_req[c*8 +: 8] = 8'h00;
          else               ch_req[c*8 +: 8] = 8'($urandom);
        end
        ch_data[c*8 +: 8] = 8'($urandom);
        ch_sop[c] = ($urandom_range(3) == 0);
        ch_eop[c] = ($urandom_range(3) == 0);
        ch_qos[c] = 1'($urandom_range(1));
      end
      tick("rnd");
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
